// File: rtl/gate_vector_checker_pkg.sv
// Shared constants for the gate vector checker: FSM encodings and
// truth tables for common 2-input gates (bit i = Y for {A,B}=i).
package gate_vector_checker_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Bundle between the checker (master) and the gate under test / host (slave).
interface gate_vector_checker_if;

    logic       start;
    logic       A;
    logic       B;
    logic       Y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;

    modport master (
        input  start, Y,
        output A, B, busy, done, pass, err_count, err_mask
    );

    modport slave (
        output start, Y,
        input  A, B, busy, done, pass, err_count, err_mask
    );

endinterface

// File: rtl/gate_vector_checker_hold_ctr.sv
// Hold-window counter: counts while enabled, flags the last cycle of a window.
module gate_chk_hold_ctr #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/gate_vector_checker.sv
// Walks a 2-input gate through 00,01,10,11, holding each vector for
// HOLD_CYCLES, and scores the sampled Y against a truth table.
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] EXPECT      = TT_AND,
    parameter int         CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_vector_checker_if.master bus
);

    logic [1:0] state;
    logic [1:0] vec;
    logic       busy;
    logic       done;
    logic [2:0] err_count;
    logic [3:0] err_mask;
    logic       tc;
    logic       driving;

    assign driving = (state == S_DRIVE);

    gate_chk_hold_ctr #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!driving || tc),
        .en    (driving),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec       <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
        end else begin
            case (state)
                S_DRIVE: begin
                    if (tc) begin
                        if (bus.Y != EXPECT[vec]) begin
                            err_mask[vec] <= 1'b1;
                            err_count     <= err_count + 3'd1;
                        end
                        if (vec == 2'd3) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec <= vec + 2'd1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a (re)start
                    if (bus.start) begin
                        state     <= S_DRIVE;
                        vec       <= 2'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_count <= 3'd0;
                        err_mask  <= 4'd0;
                    end
                end
            endcase
        end
    end

    assign bus.A         = vec[1];
    assign bus.B         = vec[0];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = done && (err_count == 3'd0);
    assign bus.err_count = err_count;
    assign bus.err_mask  = err_mask;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized self-checking bench: gate truth tables are drawn at random and
// every cycle is scored against a timeline model of the vector walk.
module tb_gate_vector_checker;
    import gate_vector_checker_pkg::*;

    localparam int H0 = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tt0 = TT_AND;
    int         checks = 0;
    int         errors = 0;

    gate_vector_checker_if bus0 ();
    gate_vector_checker_if bus1 ();

    assign bus0.Y = tt0[{bus0.A, bus0.B}];
    assign bus1.Y = 1'b1;

    gate_vector_checker #(
        .HOLD_CYCLES (H0),
        .EXPECT      (TT_AND),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    gate_vector_checker #(
        .HOLD_CYCLES (1),
        .EXPECT      (TT_AND),
        .CNT_W       (8)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int popc(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic chk_zero0(input string tag);
        chk({tag, "_ab"}, {bus0.A, bus0.B}, 0);
        chk({tag, "_busy"}, bus0.busy, 0);
        chk({tag, "_done"}, bus0.done, 0);
        chk({tag, "_pass"}, bus0.pass, 0);
        chk({tag, "_cnt"}, bus0.err_count, 0);
        chk({tag, "_mask"}, bus0.err_mask, 0);
    endtask

    // Called #1 after the accept edge (n=0); walks to n=4*H0.
    task automatic watch(input logic [3:0] tt, input bit rnd_start);
        logic [3:0] err;
        logic [3:0] seen;
        int         k;
        err = tt ^ TT_AND;
        for (int n = 0; n <= 4 * H0; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            k = n / H0;
            seen = err & 4'((1 << k) - 1);
            chk("ab", {bus0.A, bus0.B}, (n < 4 * H0) ? k : 3);
            chk("busy", bus0.busy, n < 4 * H0);
            chk("done", bus0.done, n == 4 * H0);
            chk("mask", bus0.err_mask, seen);
            chk("count", bus0.err_count, popc(seen));
            chk("pass", bus0.pass, (n == 4 * H0) && (err == 0));
            if (rnd_start && n < 4 * H0 - 1) bus0.start = 1'($urandom);
            else if (rnd_start) bus0.start = 1'b0;
        end
    endtask

    task automatic go0(input bit keep);
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) bus0.start = 1'b0;
    endtask

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        // reset held while start toggles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus0.start = ~bus0.start;
            bus1.start = ~bus1.start;
            @(posedge clk);
            #1;
            chk_zero0("rst");
            chk("rst1_busy", bus1.busy, 0);
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero0("idle");
        end

        // happy path: AND gate
        tt0 = TT_AND;
        go0(1'b0);
        watch(tt0, 1'b0);

        // wrong gate: OR
        tt0 = TT_OR;
        go0(1'b0);
        watch(tt0, 1'b0);

        // start held: one run, then immediate restart from DONE
        go0(1'b1);
        watch(tt0, 1'b0);
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        watch(tt0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("held_mask", bus0.err_mask, 4'b0110);
            chk("held_done", bus0.done, 1);
        end

        // random truth tables with start noise while busy
        for (int r = 0; r < 6; r++) begin
            tt0 = 4'($urandom);
            go0(1'b0);
            watch(tt0, 1'b1);
        end

        // mid-run asynchronous reset during vector 2
        tt0 = TT_OR;
        go0(1'b0);
        repeat (2 * H0 + 3) @(posedge clk);
        #2;
        chk("mid_ab_pre", {bus0.A, bus0.B}, 2);
        rst_n = 1'b0;
        #1;
        chk_zero0("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tt0 = TT_AND;
        go0(1'b0);
        watch(tt0, 1'b0);

        // HOLD_CYCLES=1 with Y stuck high
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        for (int n = 0; n <= 4; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            chk("h1_busy", bus1.busy, n < 4);
            chk("h1_done", bus1.done, n == 4);
            chk("h1_ab", {bus1.A, bus1.B}, (n < 4) ? n : 3);
        end
        chk("h1_mask", bus1.err_mask, 4'b0111);
        chk("h1_count", bus1.err_count, 3);
        chk("h1_pass", bus1.pass, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
